// File: rtl/stage_writeback_ext_pkg.sv
// Shared types and constants for the writeback stage: load funct3 codes
// and the FSM state encoding.
package stage_writeback_ext_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } wb_state_t;

endpackage

// File: rtl/stage_writeback_ext_if.sv
// Bundle of MEM-side inputs, data-memory response and writeback outputs.
// master = upstream/environment side, slave = the writeback stage.
interface stage_writeback_ext_if #(
    parameter int XLEN     = 32,
    parameter int RADDR_W  = 5,
    parameter int RETIRE_W = 32
) ();
    localparam int OFS_W = $clog2(XLEN / 8);

    logic                mem_valid;
    logic [RADDR_W-1:0]  mem_rd;
    logic                mem_wr_enable;
    logic                mem_to_reg;
    logic [2:0]          mem_funct3;
    logic [OFS_W-1:0]    mem_byte_ofs;
    logic [XLEN-1:0]     mem_alu_result;
    logic                dmem_rvalid;
    logic [XLEN-1:0]     dmem_rdata;

    logic                wb_stall;
    logic                wb_valid;
    logic [RADDR_W-1:0]  wb_rd;
    logic                wb_wr_enable;
    logic [XLEN-1:0]     wb_write_data;
    logic [RETIRE_W-1:0] wb_retire_count;

    modport master (
        output mem_valid, mem_rd, mem_wr_enable, mem_to_reg, mem_funct3,
               mem_byte_ofs, mem_alu_result, dmem_rvalid, dmem_rdata,
        input  wb_stall, wb_valid, wb_rd, wb_wr_enable, wb_write_data,
               wb_retire_count
    );

    modport slave (
        input  mem_valid, mem_rd, mem_wr_enable, mem_to_reg, mem_funct3,
               mem_byte_ofs, mem_alu_result, dmem_rvalid, dmem_rdata,
        output wb_stall, wb_valid, wb_rd, wb_wr_enable, wb_write_data,
               wb_retire_count
    );
endinterface

// File: rtl/stage_writeback_ext_load_extend.sv
// Combinational load alignment and sign/zero extension. The offset is
// rounded down to the access size, so misaligned low bits are ignored.
module load_extend
    import stage_writeback_ext_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                 funct3,
    input  logic [$clog2(XLEN/8)-1:0]  byte_ofs,
    input  logic [XLEN-1:0]            rdata,
    output logic [XLEN-1:0]            ext_data
);
    localparam int OFS_W = $clog2(XLEN / 8);

    logic [OFS_W-1:0] ofs_h;
    logic [OFS_W-1:0] ofs_w;
    logic [7:0]       b;
    logic [15:0]      h;
    logic [31:0]      w;

    // Pick the byte/half/word lane addressed by the (size-aligned) offset.
    always_comb begin
        ofs_h = byte_ofs & ~OFS_W'(1);
        ofs_w = byte_ofs & ~OFS_W'(3);
        b     = rdata[{byte_ofs, 3'b000} +: 8];
        h     = rdata[{ofs_h, 3'b000} +: 16];
        w     = rdata[{ofs_w, 3'b000} +: 32];
    end

    // Extend according to the load type; unknown codes pass the word through.
    // For XLEN=32 the word cases collapse to the raw word.
    always_comb begin
        ext_data = rdata;
        case (funct3)
            F3_LB:   ext_data = XLEN'($signed(b));
            F3_LH:   ext_data = XLEN'($signed(h));
            F3_LW:   ext_data = XLEN'($signed(w));
            F3_LBU:  ext_data = XLEN'(b);
            F3_LHU:  ext_data = XLEN'(h);
            F3_LWU:  ext_data = XLEN'(w);
            F3_LD:   ext_data = rdata;
            default: ext_data = rdata;
        endcase
    end
endmodule

// File: rtl/stage_writeback_ext.sv
// Writeback stage: retires one instruction per cycle, waits on late load
// data (stalling upstream), extends loads, masks x0 writes and counts
// retirements. All wb_* outputs except wb_stall are registered.
module stage_writeback_ext
    import stage_writeback_ext_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int RADDR_W  = 5,
    parameter int RETIRE_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    stage_writeback_ext_if.slave bus
);
    localparam int OFS_W = $clog2(XLEN / 8);

    wb_state_t           state;
    logic [RADDR_W-1:0]  lat_rd;
    logic [2:0]          lat_funct3;
    logic [OFS_W-1:0]    lat_ofs;
    logic                lat_wr_enable;

    logic                wb_valid_q;
    logic [RADDR_W-1:0]  wb_rd_q;
    logic                wb_wr_enable_q;
    logic [XLEN-1:0]     wb_write_data_q;
    logic [RETIRE_W-1:0] retire_count_q;

    logic                in_wait;
    logic [2:0]          sel_funct3;
    logic [OFS_W-1:0]    sel_ofs;
    logic [XLEN-1:0]     ext_data;
    logic                retire_now;
    logic [RADDR_W-1:0]  retire_rd;
    logic                retire_we;
    logic [XLEN-1:0]     retire_data;
    logic                load_miss;

    assign in_wait   = (state == WAIT_LOAD);
    assign load_miss = !in_wait && bus.mem_valid && bus.mem_to_reg && !bus.dmem_rvalid;

    // While waiting, decode the response with the fields captured at issue.
    assign sel_funct3 = in_wait ? lat_funct3 : bus.mem_funct3;
    assign sel_ofs    = in_wait ? lat_ofs    : bus.mem_byte_ofs;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .funct3   (sel_funct3),
        .byte_ofs (sel_ofs),
        .rdata    (bus.dmem_rdata),
        .ext_data (ext_data)
    );

    // Decide whether something retires on the coming edge and with what.
    always_comb begin
        retire_now  = 1'b0;
        retire_rd   = bus.mem_rd;
        retire_we   = bus.mem_wr_enable;
        retire_data = bus.mem_alu_result;
        if (in_wait) begin
            retire_now  = bus.dmem_rvalid;
            retire_rd   = lat_rd;
            retire_we   = lat_wr_enable;
            retire_data = ext_data;
        end else if (bus.mem_valid && (!bus.mem_to_reg || bus.dmem_rvalid)) begin
            retire_now  = 1'b1;
            retire_data = bus.mem_to_reg ? ext_data : bus.mem_alu_result;
        end
    end

    // Upstream holds while a load is outstanding and its data is not here yet.
    assign bus.wb_stall = load_miss || (in_wait && !bus.dmem_rvalid);

    // FSM, captured load fields, output registers and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            lat_rd          <= '0;
            lat_funct3      <= '0;
            lat_ofs         <= '0;
            lat_wr_enable   <= 1'b0;
            wb_valid_q      <= 1'b0;
            wb_rd_q         <= '0;
            wb_wr_enable_q  <= 1'b0;
            wb_write_data_q <= '0;
            retire_count_q  <= '0;
        end else begin
            wb_valid_q     <= retire_now;
            wb_wr_enable_q <= retire_now && retire_we && (retire_rd != '0);
            if (retire_now) begin
                wb_rd_q         <= retire_rd;
                wb_write_data_q <= retire_data;
                retire_count_q  <= retire_count_q + RETIRE_W'(1);
            end
            case (state)
                IDLE: begin
                    if (load_miss) begin
                        lat_rd        <= bus.mem_rd;
                        lat_funct3    <= bus.mem_funct3;
                        lat_ofs       <= bus.mem_byte_ofs;
                        lat_wr_enable <= bus.mem_wr_enable;
                        state         <= WAIT_LOAD;
                    end
                end
                WAIT_LOAD: begin
                    if (bus.dmem_rvalid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.wb_valid        = wb_valid_q;
    assign bus.wb_rd           = wb_rd_q;
    assign bus.wb_wr_enable    = wb_wr_enable_q;
    assign bus.wb_write_data   = wb_write_data_q;
    assign bus.wb_retire_count = retire_count_q;
endmodule
